// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared types and default constants for the hangman game core
package hangman_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_e;

    localparam int WORD_LEN    = 4;
    localparam int CODE_W      = 5;
    localparam int MAX_MISSES  = 6;
    localparam int HIDDEN_CODE = 15;

endpackage

// File: rtl/guess_tracker_if.sv
// rtl/guess_tracker_if.sv - load/guess/display bundle between game controller and game core
interface guess_tracker_if #(
    parameter int WORD_LEN = hangman_pkg::WORD_LEN,
    parameter int CODE_W   = hangman_pkg::CODE_W
) ();

    logic                         load_valid;
    logic [2:0]                   load_pos;
    logic [CODE_W-1:0]            load_code;
    logic                         start;
    logic                         guess_valid;
    logic [CODE_W-1:0]            guess_code;
    logic                         guess_ready;
    logic [WORD_LEN*CODE_W-1:0]   slot_code;
    logic [WORD_LEN-1:0]          revealed;
    logic [2:0]                   miss_count;
    logic                         hit_p;
    logic                         miss_p;
    logic                         repeat_p;
    logic                         game_won;
    logic                         game_lost;

    modport master (
        output load_valid, load_pos, load_code, start, guess_valid, guess_code,
        input  guess_ready, slot_code, revealed, miss_count,
        input  hit_p, miss_p, repeat_p, game_won, game_lost
    );

    modport slave (
        input  load_valid, load_pos, load_code, start, guess_valid, guess_code,
        output guess_ready, slot_code, revealed, miss_count,
        output hit_p, miss_p, repeat_p, game_won, game_lost
    );

endinterface

// File: rtl/guess_tracker_slot_match.sv
// rtl/guess_tracker_slot_match.sv - per-slot equality of the secret word against one code
module slot_match #(
    parameter int WORD_LEN = hangman_pkg::WORD_LEN,
    parameter int CODE_W   = hangman_pkg::CODE_W
) (
    input  logic [WORD_LEN*CODE_W-1:0] word_i,
    input  logic [CODE_W-1:0]          code_i,
    output logic [WORD_LEN-1:0]        match_o
);

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_cmp
        assign match_o[i] = (word_i[i*CODE_W +: CODE_W] == code_i);
    end

endmodule

// File: rtl/guess_tracker.sv
// rtl/guess_tracker.sv - hangman game core: secret word, guess tracking, reveal state, game FSM
module guess_tracker #(
    parameter int WORD_LEN    = hangman_pkg::WORD_LEN,
    parameter int CODE_W      = hangman_pkg::CODE_W,
    parameter int MAX_MISSES  = hangman_pkg::MAX_MISSES,
    parameter int HIDDEN_CODE = hangman_pkg::HIDDEN_CODE
) (
    input  logic             clk,
    input  logic             reset,
    guess_tracker_if.slave   bus
);
    import hangman_pkg::*;

    localparam int          NUM_CODES = 1 << CODE_W;
    localparam logic [2:0]  MAX_M     = 3'(MAX_MISSES);

    state_e                      state_q, state_d;
    logic [WORD_LEN*CODE_W-1:0]  word_q, word_d;
    logic [WORD_LEN-1:0]         rev_q, rev_d;
    logic [NUM_CODES-1:0]        used_q, used_d;
    logic [2:0]                  miss_q, miss_d;
    logic                        hit_q, hit_d;
    logic                        mp_q, mp_d;
    logic                        rep_q, rep_d;

    logic [CODE_W-1:0]           cmp_code;
    logic [WORD_LEN-1:0]         match;

    // One comparator bank: in IDLE it finds blank (code 0) slots, in PLAY it matches the guess.
    assign cmp_code = (state_q == S_IDLE) ? '0 : bus.guess_code;

    slot_match #(
        .WORD_LEN (WORD_LEN),
        .CODE_W   (CODE_W)
    ) u_slot_match (
        .word_i  (word_q),
        .code_i  (cmp_code),
        .match_o (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            rev_q   <= '0;
            used_q  <= '0;
            miss_q  <= '0;
            hit_q   <= 1'b0;
            mp_q    <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            rev_q   <= rev_d;
            used_q  <= used_d;
            miss_q  <= miss_d;
            hit_q   <= hit_d;
            mp_q    <= mp_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rev_d   = rev_q;
        used_d  = used_q;
        miss_d  = miss_q;
        hit_d   = 1'b0;
        mp_d    = 1'b0;
        rep_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (&match) ? S_WON : S_PLAY;
                    used_d  = '0;
                    miss_d  = '0;
                    rev_d   = match;
                end else if (bus.load_valid) begin
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (bus.load_pos == 3'(i)) begin
                            word_d[i*CODE_W +: CODE_W] = bus.load_code;
                        end
                    end
                end
            end

            S_PLAY: begin
                if (bus.guess_valid && (bus.guess_code != '0)) begin
                    if (used_q[bus.guess_code]) begin
                        rep_d = 1'b1;
                    end else begin
                        used_d[bus.guess_code] = 1'b1;
                        rev_d = rev_q | match;
                        if (|match) begin
                            hit_d = 1'b1;
                        end else begin
                            mp_d = 1'b1;
                            if (miss_q < MAX_M) begin
                                miss_d = miss_q + 3'd1;
                            end
                        end
                        if (&rev_d) begin
                            state_d = S_WON;
                        end else if (miss_d == MAX_M) begin
                            state_d = S_LOST;
                            rev_d   = '1;
                        end
                    end
                end
            end

            S_WON, S_LOST: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                    rev_d   = '0;
                    used_d  = '0;
                    miss_d  = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        assign bus.slot_code[i*CODE_W +: CODE_W] =
            rev_q[i] ? word_q[i*CODE_W +: CODE_W] : CODE_W'(HIDDEN_CODE);
    end

    assign bus.guess_ready = (state_q == S_PLAY);
    assign bus.revealed    = rev_q;
    assign bus.miss_count  = miss_q;
    assign bus.hit_p       = hit_q;
    assign bus.miss_p      = mp_q;
    assign bus.repeat_p    = rep_q;
    assign bus.game_won    = (state_q == S_WON);
    assign bus.game_lost   = (state_q == S_LOST);

endmodule
